apb_gpiox: RTL and testbench
============================

Name: apb_gpiox

Overview:
Parametrised APB GPIO, successor to the 8-bit fixed GPIO peripheral. It provides per-pin direction and output data, and an atomic set/reset register for output bits. Inputs pass through a multi-stage synchroniser and per-pin rising/falling edge detection. Edge events latch into a W1C interrupt status register, which drives a single level IRQ to the system interrupt controller. It sits on the APB bus beside the other memory-mapped peripherals.

Parameters:
- NPIN, 8, number of GPIO pins; legal range 1..16.
- SYNC_STAGES, 2, synchroniser flop stages on pad input; minimum 2.
- DB_W, 16, width of the debounce prescaler register. Used only with GPIOX_DEBOUNCE_EN.

Ports:
- PCLK  in  1  single clock.
- PRESETn  in  1  reset, synchronous, active-low.
- PADDR  in  5  byte address; word index is PADDR[4:2].
- PWRITE  in  1  APB write.
- PENABLE  in  1  APB enable.
- PWDATA  in  32  write data.
- PSEL  in  1  slave select.
- PRDATA  out  32  read data (registered).
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  error; asserted with PREADY on a write to a read-only register.
- gpio  inout  NPIN  pads.
- irq  out  1  OR of (ISR) bits.

Behaviour:
- Reset: while PRESETn is sampled low at a PCLK edge, all registers clear; PRDATA, PREADY, PSLVERR and irq are 0; all pads are hi-Z. Synchroniser and edge-history flops clear to 0.
- APB handshake:
  - A transfer executes on the edge where PSEL && PENABLE && !PREADY.
  - PREADY is registered high for exactly one cycle after that edge, then low. This gives one wait state and single execution per transfer.
  - Write data commits on the execute edge.
  - On a read, PRDATA loads on the execute edge and holds until the next read.
- Register map (word offset, access; unused upper bits read 0):
  - 0x00 CR, RW: direction, 1 = output.
  - 0x04 ODR, RW: output data.
  - 0x08 IDR, RO: conditioned input.
  - 0x0C BSRR, WO, reads 0: PWDATA[NPIN-1:0] sets ODR bits; PWDATA[16+NPIN-1:16] clears ODR bits. If both are set for the same bit, set wins.
  - 0x10 RISE_EN, RW.
  - 0x14 FALL_EN, RW.
  - 0x18 ISR, RW1C.
  - 0x1C DBCNT, RW (feature only).
- PSLVERR: a write to 0x08 asserts PSLVERR with PREADY and has no effect. Reads never error.
- Pad drive: gpio[i] = CR[i] ? ODR[i] : Z. The input path always samples the pad, so output pins read back their driven value.
- Input conditioning:
  - Pad → SYNC_STAGES flops → sync.
  - cond = sync, or the debounced value when the feature is enabled.
  - IDR = cond, so IDR lags a pad change by SYNC_STAGES cycles.
- Edge detection:
  - prev <= cond each cycle.
  - rise = cond & ~prev; fall = ~cond & prev.
  - ISR[i] sets when (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
- Simultaneous events: an ISR set event and a W1C clear of the same bit on the same edge leave the bit at 1 (set wins).
- irq: registered, so it is 1 one cycle after any ISR bit becomes 1.
- Reset mid-transfer: PREADY drops, and the transfer is lost; the master must retry.

Optional Feature:
Macro: GPIOX_DEBOUNCE_EN.
- Defined:
  - Prescaler counts 0..DBCNT and emits a 1-cycle tick when it reaches DBCNT, then wraps to 0. DBCNT=0 gives a tick every cycle.
  - Each pin has a 3-bit shift register of sync sampled on each tick.
  - cond[i] updates to the sampled value only when all 3 samples agree; otherwise it holds.
  - A write to DBCNT restarts the prescaler at 0.
- Undefined: cond = sync; DBCNT reads 0 and writes are ignored (no PSLVERR).

Decomposition:
- Package gpiox_pkg holds:
  - Offset localparams: ADDR_CR, ADDR_ODR, ADDR_IDR, ADDR_BSRR, ADDR_RISE, ADDR_FALL, ADDR_ISR, ADDR_DBCNT.
  - An enum for the 3-bit word index.
- One sub-module, gpiox_in_cond: synchroniser, optional debounce and edge detect. It outputs cond, rise and fall.

Test Plan:
- NPIN=8: write CR=0xFF, then ODR=0xA5. gpio reads 0xA5. Read IDR returns 0x000000A5. PREADY is high 1 cycle per access.
- ODR=0x0F, then write BSRR=0x00030030. ODR=0x3C. Then BSRR=0x00010001: bit0 stays 1 (set wins).
- CR=0, RISE_EN=0x01, pad0 driven 0→1:
  - ISR=0x01 at SYNC_STAGES+1 cycles; irq follows 1 cycle later.
  - Write ISR=0x01: ISR=0, irq=0.
  - A pad edge landing on the same edge as the W1C leaves ISR=0x01.
- FALL_EN=0x80, pad7 driven 1→0→1: ISR=0x80 only; the rising edge does not set it.
- Write 0x08 with 0xFF: PSLVERR=1 with PREADY; IDR unchanged. Hold PRESETn low one edge mid-transfer: all registers 0, PREADY=0.
- With GPIOX_DEBOUNCE_EN, DBCNT=3:
  - A 5-cycle pad glitch leaves IDR unchanged.
  - A pulse of ≥12 cycles updates IDR.
  - Without the macro, a DBCNT write then read returns 0.

Source files
------------

// File: rtl/gpiox_pkg.sv
// Shared register offsets and word-index enum for the apb_gpiox peripheral.
package gpiox_pkg;

  localparam logic [4:0] ADDR_CR    = 5'h00;
  localparam logic [4:0] ADDR_ODR   = 5'h04;
  localparam logic [4:0] ADDR_IDR   = 5'h08;
  localparam logic [4:0] ADDR_BSRR  = 5'h0C;
  localparam logic [4:0] ADDR_RISE  = 5'h10;
  localparam logic [4:0] ADDR_FALL  = 5'h14;
  localparam logic [4:0] ADDR_ISR   = 5'h18;
  localparam logic [4:0] ADDR_DBCNT = 5'h1C;

  typedef enum logic [2:0] {
    REG_CR    = ADDR_CR[4:2],
    REG_ODR   = ADDR_ODR[4:2],
    REG_IDR   = ADDR_IDR[4:2],
    REG_BSRR  = ADDR_BSRR[4:2],
    REG_RISE  = ADDR_RISE[4:2],
    REG_FALL  = ADDR_FALL[4:2],
    REG_ISR   = ADDR_ISR[4:2],
    REG_DBCNT = ADDR_DBCNT[4:2]
  } gpiox_reg_e;

  // Zero-extend a pin vector (up to 16 pins) onto the 32-bit read bus.
  function automatic logic [31:0] pin_word(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

endpackage

// File: rtl/gpiox_in_cond.sv
// Pad input conditioning: multi-stage synchroniser, optional debounce
// (GPIOX_DEBOUNCE_EN) and per-pin rising/falling edge detection.
module gpiox_in_cond
  import gpiox_pkg::*;
#(
  parameter int NPIN        = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DB_W        = 16
) (
  input  logic            PCLK,
  input  logic            PRESETn,
  input  logic [NPIN-1:0] pad,
`ifdef GPIOX_DEBOUNCE_EN
  input  logic [DB_W-1:0] dbcnt,
  input  logic            db_restart,
`endif
  output logic [NPIN-1:0] cond,
  output logic [NPIN-1:0] rise,
  output logic [NPIN-1:0] fall
);

  logic [NPIN-1:0] sync_reg [SYNC_STAGES];
  logic [NPIN-1:0] sync;
  logic [NPIN-1:0] prev_reg;

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_reg[s] <= '0;
    end else begin
      sync_reg[0] <= pad;
      for (int s = 1; s < SYNC_STAGES; s++) sync_reg[s] <= sync_reg[s-1];
    end
  end

  assign sync = sync_reg[SYNC_STAGES-1];

`ifdef GPIOX_DEBOUNCE_EN
  logic [DB_W-1:0] pre_reg;
  logic            tick;

  assign tick = (pre_reg == dbcnt);

  always_ff @(posedge PCLK) begin
    if (!PRESETn || db_restart) pre_reg <= '0;
    else if (tick)              pre_reg <= '0;
    else                        pre_reg <= pre_reg + 1'b1;
  end

  // cond only moves once three consecutive tick samples agree.
  for (genvar gi = 0; gi < NPIN; gi++) begin : g_db
    logic [2:0] sh_reg;
    logic       db_reg;
    always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
        sh_reg <= '0;
        db_reg <= 1'b0;
      end else begin
        if (tick) sh_reg <= {sh_reg[1:0], sync[gi]};
        if (sh_reg == 3'b111)      db_reg <= 1'b1;
        else if (sh_reg == 3'b000) db_reg <= 1'b0;
      end
    end
    assign cond[gi] = db_reg;
  end
`else
  assign cond = sync;
`endif

  always_ff @(posedge PCLK) begin
    if (!PRESETn) prev_reg <= '0;
    else          prev_reg <= cond;
  end

  assign rise = cond & ~prev_reg;
  assign fall = ~cond & prev_reg;

endmodule

// File: rtl/apb_gpiox.sv
// Parametrised APB GPIO with set/reset register and edge interrupts.
// Optional input debounce is built when GPIOX_DEBOUNCE_EN is defined.
module apb_gpiox
  import gpiox_pkg::*;
#(
  parameter int NPIN        = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DB_W        = 16
) (
  input  logic            PCLK,
  input  logic            PRESETn,
  input  logic [4:0]      PADDR,
  input  logic            PWRITE,
  input  logic            PENABLE,
  input  logic [31:0]     PWDATA,
  input  logic            PSEL,
  output logic [31:0]     PRDATA,
  output logic            PREADY,
  output logic            PSLVERR,
  inout  wire  [NPIN-1:0] gpio,
  output logic            irq
);

  logic [NPIN-1:0] cr_reg, cr_next;
  logic [NPIN-1:0] odr_reg, odr_next;
  logic [NPIN-1:0] rise_en_reg, rise_en_next;
  logic [NPIN-1:0] fall_en_reg, fall_en_next;
  logic [NPIN-1:0] isr_reg, isr_next;
  logic [NPIN-1:0] isr_clr;
  logic [NPIN-1:0] cond, rise, fall, set_ev;
  logic [31:0]     prdata_reg, rd_word;
  logic            pready_reg, pslverr_reg, irq_reg;
  logic            exec, wr_exec, rd_exec, db_wr;
  gpiox_reg_e      widx;
  logic            unused_ok;

  assign widx    = gpiox_reg_e'(PADDR[4:2]);
  assign exec    = PSEL && PENABLE && !pready_reg;
  assign wr_exec = exec && PWRITE;
  assign rd_exec = exec && !PWRITE;

`ifdef GPIOX_DEBOUNCE_EN
  logic [DB_W-1:0] dbcnt_reg;

  always_ff @(posedge PCLK) begin
    if (!PRESETn)   dbcnt_reg <= '0;
    else if (db_wr) dbcnt_reg <= DB_W'(PWDATA);
  end
`endif

  gpiox_in_cond #(
    .NPIN        (NPIN),
    .SYNC_STAGES (SYNC_STAGES),
    .DB_W        (DB_W)
  ) u_in_cond (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .pad        (gpio),
`ifdef GPIOX_DEBOUNCE_EN
    .dbcnt      (dbcnt_reg),
    .db_restart (db_wr),
`endif
    .cond       (cond),
    .rise       (rise),
    .fall       (fall)
  );

  for (genvar gi = 0; gi < NPIN; gi++) begin : g_pad
    assign gpio[gi] = cr_reg[gi] ? odr_reg[gi] : 1'bz;
  end

  assign set_ev = (rise & rise_en_reg) | (fall & fall_en_reg);

  always_comb begin
    cr_next      = cr_reg;
    odr_next     = odr_reg;
    rise_en_next = rise_en_reg;
    fall_en_next = fall_en_reg;
    isr_clr      = '0;
    db_wr        = 1'b0;
    if (wr_exec) begin
      case (widx)
        REG_CR:    cr_next      = PWDATA[NPIN-1:0];
        REG_ODR:   odr_next     = PWDATA[NPIN-1:0];
        // Set term is OR-ed last so it overrides a clear of the same bit.
        REG_BSRR:  odr_next     = (odr_reg & ~PWDATA[16 +: NPIN]) | PWDATA[NPIN-1:0];
        REG_RISE:  rise_en_next = PWDATA[NPIN-1:0];
        REG_FALL:  fall_en_next = PWDATA[NPIN-1:0];
        REG_ISR:   isr_clr      = PWDATA[NPIN-1:0];
        REG_DBCNT: db_wr        = 1'b1;
        default:   ;
      endcase
    end
    isr_next = (isr_reg & ~isr_clr) | set_ev;
  end

  always_comb begin
    rd_word = '0;
    case (widx)
      REG_CR:    rd_word = pin_word(16'(cr_reg));
      REG_ODR:   rd_word = pin_word(16'(odr_reg));
      REG_IDR:   rd_word = pin_word(16'(cond));
      REG_RISE:  rd_word = pin_word(16'(rise_en_reg));
      REG_FALL:  rd_word = pin_word(16'(fall_en_reg));
      REG_ISR:   rd_word = pin_word(16'(isr_reg));
`ifdef GPIOX_DEBOUNCE_EN
      REG_DBCNT: rd_word = 32'(dbcnt_reg);
`endif
      default:   rd_word = '0;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      cr_reg      <= '0;
      odr_reg     <= '0;
      rise_en_reg <= '0;
      fall_en_reg <= '0;
      isr_reg     <= '0;
      prdata_reg  <= '0;
      pready_reg  <= 1'b0;
      pslverr_reg <= 1'b0;
      irq_reg     <= 1'b0;
    end else begin
      cr_reg      <= cr_next;
      odr_reg     <= odr_next;
      rise_en_reg <= rise_en_next;
      fall_en_reg <= fall_en_next;
      isr_reg     <= isr_next;
      pready_reg  <= exec;
      pslverr_reg <= wr_exec && (widx == REG_IDR);
      irq_reg     <= |isr_reg;
      if (rd_exec) prdata_reg <= rd_word;
    end
  end

  assign PRDATA  = prdata_reg;
  assign PREADY  = pready_reg;
  assign PSLVERR = pslverr_reg;
  assign irq     = irq_reg;

  assign unused_ok = ^{PADDR[1:0], PWDATA, 32'(DB_W)};

endmodule

// File: tb/tb_apb_gpiox.sv
// Directed self-checking bench for apb_gpiox (NPIN=8, SYNC_STAGES=2).
`timescale 1ns/1ps
module tb_apb_gpiox;

  localparam int NPIN        = 8;
  localparam int SYNC_STAGES = 2;
`ifdef GPIOX_DEBOUNCE_EN
  localparam int ISR_LAT = SYNC_STAGES + 5;
`else
  localparam int ISR_LAT = SYNC_STAGES + 1;
`endif

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [4:0]  PADDR;
  logic        PWRITE, PENABLE, PSEL;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, irq;
  wire  [NPIN-1:0] gpio;
  logic [NPIN-1:0] tb_en, tb_val;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] rd;
  logic        last_err, last_one;

  always #5 PCLK = ~PCLK;

  for (genvar gi = 0; gi < NPIN; gi++) begin : g_drv
    assign gpio[gi] = tb_en[gi] ? tb_val[gi] : 1'bz;
  end

  apb_gpiox #(.NPIN(NPIN), .SYNC_STAGES(SYNC_STAGES), .DB_W(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PWRITE(PWRITE),
    .PENABLE(PENABLE), .PWDATA(PWDATA), .PSEL(PSEL), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .gpio(gpio), .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic apb_xfer(input logic wr, input logic [4:0] addr, input logic [31:0] wdata);
    int waited;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = wr; PADDR = addr; PWDATA = wdata; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    waited = 0;
    do begin
      @(posedge PCLK); #1;
      waited++;
    end while (!PREADY && waited < 8);
    if (!PREADY) check("pready_timeout", {31'b0, PREADY}, 32'd1);
    rd = PRDATA;
    last_err = PSLVERR;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    @(posedge PCLK); #1;
    last_one = (waited == 1) && !PREADY;
  endtask

  task automatic apb_write(input logic [4:0] addr, input logic [31:0] wdata);
    apb_xfer(1'b1, addr, wdata);
  endtask

  task automatic apb_read(input logic [4:0] addr);
    apb_xfer(1'b0, addr, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
    tb_en = '0; tb_val = '0;
    PRESETn = 1'b0;
    repeat (3) @(posedge PCLK);
    #1 PRESETn = 1'b1;

    check("rst_pready",  {31'b0, PREADY},  32'd0);
    check("rst_pslverr", {31'b0, PSLVERR}, 32'd0);
    check("rst_irq",     {31'b0, irq},     32'd0);
    check("rst_prdata",  PRDATA,           32'd0);
    apb_read(5'h00);
    check("rst_cr", rd, 32'd0);
    check("rd_rdy_1cyc", {31'b0, last_one}, 32'd1);

    // Output drive and readback
    apb_write(5'h00, 32'h0000_00FF);
    apb_write(5'h04, 32'h0000_00A5);
    check("wr_rdy_1cyc", {31'b0, last_one}, 32'd1);
    check("wr_no_err",   {31'b0, last_err}, 32'd0);
    check("gpio_drive",  {24'b0, gpio},     32'h0000_00A5);
    apb_read(5'h08);
    check("idr_loop", rd, 32'h0000_00A5);

    // Atomic set/reset
    apb_write(5'h04, 32'h0000_000F);
    apb_write(5'h0C, 32'h0003_0030);
    apb_read(5'h04);
    check("bsrr_odr", rd, 32'h0000_003C);
    apb_write(5'h0C, 32'h0001_0001);
    apb_read(5'h04);
    check("bsrr_setwins", rd, 32'h0000_003D);
    apb_read(5'h0C);
    check("bsrr_rd0", rd, 32'd0);

    // Pads become inputs driven by the bench
    apb_write(5'h00, 32'h0);
    tb_val = '0; tb_en = '1;
    repeat (12) @(posedge PCLK);
    apb_write(5'h10, 32'h01);
    apb_read(5'h10);
    check("rise_en_rd", rd, 32'h01);

    @(posedge PCLK); #1 tb_val[0] = 1'b1;
    repeat (ISR_LAT) @(posedge PCLK);
    #1 check("irq_lat_lo", {31'b0, irq}, 32'd0);
    @(posedge PCLK); #1 check("irq_lat_hi", {31'b0, irq}, 32'd1);
    apb_read(5'h18);
    check("isr_rise", rd, 32'h01);
    apb_write(5'h18, 32'h01);
    apb_read(5'h18);
    check("isr_w1c", rd, 32'h00);
    check("irq_w1c", {31'b0, irq}, 32'd0);

    tb_val[0] = 1'b0;
    repeat (ISR_LAT + 3) @(posedge PCLK);
    apb_read(5'h18);
    check("isr_fall_noen", rd, 32'h00);

    // Rise on pin 0 coincides with the W1C execute edge
    @(posedge PCLK); #1 tb_val[0] = 1'b1;
    repeat (ISR_LAT - 3) @(posedge PCLK);
    apb_write(5'h18, 32'h01);
    apb_read(5'h18);
    check("isr_setwins", rd, 32'h01);
    apb_write(5'h18, 32'h01);

    // Falling-edge enable on pin 7 only
    apb_write(5'h10, 32'h00);
    apb_write(5'h14, 32'h80);
    @(posedge PCLK); #1 tb_val[7] = 1'b1;
    repeat (ISR_LAT + 3) @(posedge PCLK);
    apb_read(5'h18);
    check("isr_rise7_ign", rd, 32'h00);
    #1 tb_val[7] = 1'b0;
    repeat (ISR_LAT + 3) @(posedge PCLK);
    apb_read(5'h18);
    check("isr_fall7", rd, 32'h80);
    check("irq_fall7", {31'b0, irq}, 32'd1);
    apb_write(5'h18, 32'h80);
    #1 tb_val[7] = 1'b1;
    repeat (ISR_LAT + 3) @(posedge PCLK);
    apb_read(5'h18);
    check("isr_rise7_after", rd, 32'h00);
    #1 tb_val[7] = 1'b0;
    repeat (ISR_LAT + 3) @(posedge PCLK);

    // Read-only IDR write
    apb_read(5'h08);
    check("idr_pre", rd, 32'h01);
    apb_write(5'h08, 32'hFF);
    check("idr_wr_err", {31'b0, last_err}, 32'd1);
    check("err_rdy_1cyc", {31'b0, last_one}, 32'd1);
    apb_read(5'h08);
    check("idr_post", rd, 32'h01);
    check("rd_no_err", {31'b0, last_err}, 32'd0);

    // Reset landing on the execute edge of a write
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = 5'h04; PWDATA = 32'h77;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; PRESETn = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    check("mid_rst_pready", {31'b0, PREADY}, 32'd0);
    check("mid_rst_prdata", PRDATA, 32'd0);
    check("mid_rst_irq", {31'b0, irq}, 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    apb_read(5'h04);
    check("mid_rst_odr", rd, 32'd0);
    apb_read(5'h14);
    check("mid_rst_fall", rd, 32'd0);
    apb_read(5'h18);
    check("mid_rst_isr", rd, 32'd0);

`ifdef GPIOX_DEBOUNCE_EN
    apb_write(5'h1C, 32'd3);
    apb_read(5'h1C);
    check("dbcnt_rd", rd, 32'd3);
    repeat (20) @(posedge PCLK);
    apb_read(5'h08);
    check("db_idr_base", rd, 32'h01);
    #1 tb_val[1] = 1'b1;
    repeat (5) @(posedge PCLK);
    #1 tb_val[1] = 1'b0;
    repeat (20) @(posedge PCLK);
    apb_read(5'h08);
    check("db_glitch", rd, 32'h01);
    #1 tb_val[1] = 1'b1;
    repeat (14) @(posedge PCLK);
    apb_read(5'h08);
    check("db_pulse", rd, 32'h03);
    tb_val[1] = 1'b0;
`else
    apb_write(5'h1C, 32'd5);
    check("dbcnt_wr_err", {31'b0, last_err}, 32'd0);
    apb_read(5'h1C);
    check("dbcnt_rd0", rd, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
